// File: rtl/trace_pkg.sv
// trace_pkg: shared record layout, kind bit indices and default widths for the commit-trace buffer
//   trace_rec_t : {ts, kind[2:0], rd, rf_data, addr, mem_data} at default widths
//   KIND_*      : bit positions inside kind ({mem_rd, mem_wr, rf_wr})
//   pack_kind   : builds the kind field from the three event flags
package trace_pkg;
    localparam int DATA_W_DEF  = 32;
    localparam int DM_ADDR_DEF = 9;
    localparam int TS_W_DEF    = 16;
    localparam int KIND_RF     = 0;
    localparam int KIND_MW     = 1;
    localparam int KIND_MR     = 2;
    typedef struct packed {
        logic [TS_W_DEF-1:0]    ts;
        logic [2:0]             kind;
        logic [4:0]             rd;
        logic [DATA_W_DEF-1:0]  rf_data;
        logic [DM_ADDR_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0]  mem_data;
    } trace_rec_t;
    function automatic logic [2:0] pack_kind(input logic rf, input logic mw, input logic mr);
        logic [2:0] k;
        k = '0;
        k[KIND_RF] = rf;
        k[KIND_MW] = mw;
        k[KIND_MR] = mr;
        return k;
    endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO of trace records with separate occupancy counter
//   clk, reset (async active-low), clear (sync flush, wins over push/pop)
//   push/din  : store din when not full, or when full and a pop frees a slot
//   pop       : advance head when not empty
//   head      : current head slot, unregistered
//   full, empty, count : occupancy status
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter type rec_t = trace_rec_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  rec_t                     din,
    input  logic                     pop,
    output rec_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    rec_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    assign empty   = cnt_q == '0;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty && !clear;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && !clear && (!full || do_pop);
    assign head    = mem_q[rd_q];
    assign count   = cnt_q;
    always_comb begin
        wr_d  = clear ? '0 : wr_q + AW'(do_push);
        rd_d  = clear ? '0 : rd_q + AW'(do_pop);
        cnt_d = clear ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    // storage is cleared on reset so the head outputs read zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end
endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: packs writeback/data-memory events into timestamped records and queues them
//   clk, reset (async active-low), clear (sync flush of queue, counters and timestamp)
//   rf_we/rf_num/rf_data            : register writeback debug port
//   dm_wr/dm_rd/dm_addr/dm_wdata/dm_rdata : data-memory port
//   out_valid/out_ready/out_*       : head record, popped on valid && ready
//   count, overflow, drop_cnt       : occupancy, sticky drop flag, saturating drop count
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int TS_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    rf_we,
    input  logic [4:0]              rf_num,
    input  logic [DATA_W-1:0]       rf_data,
    input  logic                    dm_wr,
    input  logic                    dm_rd,
    input  logic [DM_ADDRESS-1:0]   dm_addr,
    input  logic [DATA_W-1:0]       dm_wdata,
    input  logic [DATA_W-1:0]       dm_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TS_W-1:0]         out_ts,
    output logic [2:0]              out_kind,
    output logic [4:0]              out_rd,
    output logic [DATA_W-1:0]       out_rf_data,
    output logic [DM_ADDRESS-1:0]   out_addr,
    output logic [DATA_W-1:0]       out_mem_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [7:0]              drop_cnt
);
    typedef struct packed {
        logic [TS_W-1:0]       ts;
        logic [2:0]            kind;
        logic [4:0]            rd;
        logic [DATA_W-1:0]     rf_data;
        logic [DM_ADDRESS-1:0] addr;
        logic [DATA_W-1:0]     mem_data;
    } rec_t;
    logic [TS_W-1:0] ts_q, ts_d;
    logic overflow_q, overflow_d;
    logic [7:0] drop_q, drop_d;
    logic rf_wr, push, drop, full, empty;
    rec_t rec, head;
    // writes to x0 are not architectural events
    assign rf_wr = rf_we && rf_num != 5'd0;
    assign push  = (rf_wr || dm_wr || dm_rd) && !clear;
    // full implies out_valid, so out_ready alone decides whether a slot frees up
    assign drop  = push && full && !out_ready;
    always_comb begin
        rec          = '0;
        rec.ts       = ts_q;
        rec.kind     = pack_kind(rf_wr, dm_wr, dm_rd);
        rec.rd       = rf_num;
        rec.rf_data  = rf_data;
        rec.addr     = dm_addr;
        rec.mem_data = dm_wr ? dm_wdata : dm_rdata;
    end
    always_comb begin
        ts_d       = clear ? '0 : ts_q + 1'b1;
        overflow_d = clear ? 1'b0 : overflow_q | drop;
        drop_d     = clear ? '0 : drop_q + 8'(drop && drop_q != 8'hFF);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end
    trace_fifo #(.DEPTH(DEPTH), .rec_t(rec_t)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .din   (rec),
        .pop   (out_ready),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign out_valid    = !empty;
    assign out_ts       = head.ts;
    assign out_kind     = head.kind;
    assign out_rd       = head.rd;
    assign out_rf_data  = head.rf_data;
    assign out_addr     = head.addr;
    assign out_mem_data = head.mem_data;
    assign overflow     = overflow_q;
    assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed stimulus with an expected-record queue checked by a negedge monitor
module tb_wb_trace_buffer;
    logic clk = 1'b0;
    logic reset, clear = 1'b0, rf_we = 1'b0, dm_wr = 1'b0, dm_rd = 1'b0, out_ready = 1'b0;
    logic [4:0]  rf_num = '0;
    logic [31:0] rf_data = '0, dm_wdata = '0, dm_rdata = '0;
    logic [8:0]  dm_addr = '0;
    logic        out_valid, overflow;
    logic [15:0] out_ts;
    logic [2:0]  out_kind;
    logic [4:0]  out_rd;
    logic [31:0] out_rf_data, out_mem_data;
    logic [8:0]  out_addr;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;
    int total = 0, bad = 0;
    logic [15:0] tb_ts = '0;
    typedef struct {
        logic [15:0] ts;
        logic [2:0]  kind;
        logic [4:0]  rd;
        logic [31:0] rf;
        logic [8:0]  addr;
        logic [31:0] md;
    } exp_t;
    exp_t exp_q[$];

    wb_trace_buffer #(.DEPTH(8), .DATA_W(32), .DM_ADDRESS(9), .TS_W(16)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .rf_we(rf_we), .rf_num(rf_num), .rf_data(rf_data),
        .dm_wr(dm_wr), .dm_rd(dm_rd), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts), .out_kind(out_kind),
        .out_rd(out_rd), .out_rf_data(out_rf_data), .out_addr(out_addr), .out_mem_data(out_mem_data),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset)
        if (!reset) tb_ts <= '0;
        else tb_ts <= clear ? 16'd0 : tb_ts + 16'd1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, req);
        end
    endtask

    task automatic ev(input logic we, input logic [4:0] num, input logic [31:0] rfd,
                      input logic wr, input logic rd, input logic [8:0] a,
                      input logic [31:0] wd, input logic [31:0] rdd, input logic keep);
        @(posedge clk); #1;
        rf_we = we; rf_num = num; rf_data = rfd;
        dm_wr = wr; dm_rd = rd; dm_addr = a; dm_wdata = wd; dm_rdata = rdd;
        if (keep) exp_q.push_back('{tb_ts, {rd, wr, we && num != 5'd0}, num, rfd, a, wr ? wd : rdd});
    endtask

    task automatic quiet();
        @(posedge clk); #1;
        rf_we = 1'b0; dm_wr = 1'b0; dm_rd = 1'b0; clear = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_pop", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ts", 64'(out_ts), 64'(e.ts));
                chk("kind", 64'(out_kind), 64'(e.kind));
                chk("rd", 64'(out_rd), 64'(e.rd));
                chk("rf_data", 64'(out_rf_data), 64'(e.rf));
                chk("addr", 64'(out_addr), 64'(e.addr));
                chk("mem_data", 64'(out_mem_data), 64'(e.md));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_ts", 64'(out_ts), 64'd0);
        chk("rst_kind", 64'(out_kind), 64'd0);
        chk("rst_mem_data", 64'(out_mem_data), 64'd0);
        #9 reset = 1'b1;
        repeat (2) @(posedge clk);
        // first event lands in the cycle where the timestamp reads 3
        ev(1'b1, 5'd5, 32'h12345678, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0, 1'b1);
        quiet();
        @(negedge clk);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_count", 64'(count), 64'd1);
        chk("lat_ts", 64'(out_ts), 64'd3);
        chk("lat_kind", 64'(out_kind), 64'b001);
        chk("lat_rd", 64'(out_rd), 64'd5);
        chk("lat_rf_data", 64'(out_rf_data), 64'h12345678);
        @(posedge clk); #1 out_ready = 1'b1;
        // x0 write alone is not an event
        ev(1'b1, 5'd0, 32'hFFFF, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0, 1'b0);
        quiet();
        @(negedge clk);
        chk("x0_count", 64'(count), 64'd0);
        chk("x0_valid", 64'(out_valid), 64'd0);
        // combined WB+store, load, and store+load records streamed through the monitor
        ev(1'b1, 5'd7, 32'h00000077, 1'b1, 1'b0, 9'h040, 32'hDEADBEEF, 32'h0, 1'b1);
        ev(1'b0, 5'd3, 32'h00000099, 1'b0, 1'b1, 9'h041, 32'h0, 32'h000000A5, 1'b1);
        ev(1'b1, 5'd9, 32'h00000055, 1'b1, 1'b1, 9'h1FF, 32'hCAFEF00D, 32'h00001111, 1'b1);
        quiet();
        repeat (3) @(negedge clk);
        chk("stream_count", 64'(count), 64'd0);
        // overflow: ten pushes into eight slots with nothing draining
        @(posedge clk); #1 out_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            ev(1'b1, 5'(i + 1), 32'(i * 16 + 1), 1'b0, 1'b0, 9'h0, 32'h0, 32'h0, i < 8);
        quiet();
        @(negedge clk);
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_drop", 64'(drop_cnt), 64'd2);
        chk("ovf_valid", 64'(out_valid), 64'd1);
        // full with simultaneous push and pop
        ev(1'b1, 5'd20, 32'h00000ABC, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0, 1'b1);
        out_ready = 1'b1;
        quiet();
        out_ready = 1'b0;
        @(negedge clk);
        chk("pp_count", 64'(count), 64'd8);
        chk("pp_drop", 64'(drop_cnt), 64'd2);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("drain3_count", 64'(count), 64'd5);
        // clear with a coincident event that must be discarded
        ev(1'b1, 5'd4, 32'h00000044, 1'b1, 1'b0, 9'h010, 32'h1, 32'h0, 1'b0);
        clear = 1'b1;
        quiet();
        exp_q.delete();
        @(negedge clk);
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_overflow", 64'(overflow), 64'd0);
        chk("clr_drop", 64'(drop_cnt), 64'd0);
        chk("clr_valid", 64'(out_valid), 64'd0);
        // three pending entries, then asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++)
            ev(1'b1, 5'(10 + i), 32'(100 + i), 1'b1, 1'b0, 9'(i + 3), 32'(200 + i), 32'h0, 1'b1);
        quiet();
        @(negedge clk);
        chk("pend_count", 64'(count), 64'd3);
        #2 reset = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ts", 64'(out_ts), 64'd0);
        chk("arst_kind", 64'(out_kind), 64'd0);
        chk("arst_rd", 64'(out_rd), 64'd0);
        chk("arst_rf_data", 64'(out_rf_data), 64'd0);
        chk("arst_addr", 64'(out_addr), 64'd0);
        chk("arst_mem_data", 64'(out_mem_data), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        ev(1'b1, 5'd31, 32'hFEEDFACE, 1'b0, 1'b1, 9'h1AB, 32'h0, 32'h00005A5A, 1'b1);
        out_ready = 1'b1;
        quiet();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("final_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("final_count", 64'(count), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Commit-trace capture buffer sitting directly downstream of the pipelined RISC-V datapath. It consumes the datapath's writeback debug outputs (reg_num/reg_data/reg_write_sig) and data-memory port outputs (wr/reade/addr/wr_data/rd_data). Each cycle with an architectural event is packed into one timestamped record and queued in a FIFO. The FIFO drains over a valid/ready port to the testbench scoreboard or a trace UART, so commits are checked in order without stalling the core; overflow drops records and is counted.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥2
- DATA_W, 32: register/memory data width
- DM_ADDRESS, 9: data-memory address width
- TS_W, 16: timestamp width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush
- rf_we  in  1  register write strobe (reg_write_sig)
- rf_num  in  5  destination register (reg_num)
- rf_data  in  DATA_W  writeback value (reg_data)
- dm_wr  in  1  memory write enable (wr)
- dm_rd  in  1  memory read enable (reade)
- dm_addr  in  DM_ADDRESS  memory address (addr)
- dm_wdata  in  DATA_W  store data (wr_data)
- dm_rdata  in  DATA_W  load data (rd_data); valid in the same cycle as dm_rd
- out_valid  out  1  head record present
- out_ready  in  1  consumer accepts head
- out_ts  out  TS_W  event timestamp
- out_kind  out  3  {mem_rd, mem_wr, rf_wr}
- out_rd  out  5  register number
- out_rf_data  out  DATA_W  register value
- out_addr  out  DM_ADDRESS  memory address
- out_mem_data  out  DATA_W  store or load data
- count  out  $clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky drop flag
- drop_cnt  out  8  dropped records, saturating

## Operation
- Event flags, sampled each cycle:
  - rf_wr = rf_we && rf_num!=0
  - mem_wr = dm_wr
  - mem_rd = dm_rd
- Push when any flag is set. One record per cycle; a WB event and a MEM event in the same cycle share a record.
- Record fields: ts = timestamp counter value in the event cycle; rd and rf_data are captured as-is even when rf_wr=0 (consumers mask by kind).
- mem_data selection: dm_wdata if mem_wr, else dm_rdata. If dm_wr and dm_rd are both high, both kind bits are set and mem_data = dm_wdata.
- Pop on out_valid && out_ready.
- Full and push with no pop: record dropped, overflow←1, drop_cnt increments, saturating at 255.
- Full with simultaneous push and pop: no drop; count unchanged.
- Empty with simultaneous push and pop: the pop is ignored since out_valid=0; the record is stored.
- Timestamp counter: increments every cycle, wraps at 2^TS_W-1→0 silently.
- clear: count←0, overflow←0, drop_cnt←0, timestamp←0. An event in the clear cycle is discarded. clear has priority over push and pop.
- Pointers: log2(DEPTH) bits, natural wrap. count is tracked separately to distinguish full from empty.

## Timing
- Reset (reset=0, asynchronous): count=0, out_valid=0, overflow=0, drop_cnt=0, timestamp=0. out_ts, out_kind, out_rd, out_rf_data, out_addr and out_mem_data read 0 (storage cleared).
- Latency: event in cycle N → out_valid=1 in cycle N+1 when the FIFO was empty. out_* are driven from the head storage slot with no extra register stage.
- out_* remain stable while out_valid && !out_ready.
- count, overflow and drop_cnt update on the clock edge following the event.
- Reset asserted mid-drain: all entries are lost; after release, the timestamp restarts at 0 on the first rising edge.
- Throughput: one push and one pop per cycle sustained.

## Structure
- Package trace_pkg holds:
  - trace_rec_t packed struct {ts, kind[2:0], rd, rf_data, addr, mem_data}
  - KIND_RF=0, KIND_MW=1, KIND_MR=2 bit indices
- Sub-module trace_fifo: generic synchronous FIFO of trace_rec_t with push, pop, clear, full, empty and count. The top level holds event packing, the timestamp counter, and drop accounting.

## Test plan
- Reset release, then rf_we=1 with rf_num=5 and rf_data=0x12345678 at timestamp 3 → next cycle out_valid=1, out_kind=001, out_rd=5, out_rf_data=0x12345678, out_ts=3.
- rf_we=1 with rf_num=0 and no memory activity → no push; count stays 0.
- Same cycle: rf_we with rf_num=7, plus dm_wr with addr=0x40 and wdata=0xDEADBEEF → single record with kind=011, out_addr=0x40, out_mem_data=0xDEADBEEF. A later dm_rd with rdata=0xA5 gives kind=100, mem_data=0xA5.
- out_ready=0, push 10 events with DEPTH=8 → count=8, overflow=1, drop_cnt=2. Draining returns the first 8 in order with ascending ts.
- FIFO full with push and pop in the same cycle → count stays 8, drop_cnt unchanged. Then clear → count=0, overflow=0, out_valid=0 next cycle.
- Hold reset=0 for 2 cycles while 3 entries are pending → all outputs 0 immediately, without waiting for a clock edge.
